openflow_reg_ring_master: RTL and testbench

Register-ring master for the openflow switch register bus. It arbitrates round-robin between `NUM_REQ` register requesters (host bridge, management engine, …). It injects one transaction at a time into the head of the switch register ring and collects the result from the ring tail. Each transaction completes with OK, MISS (no switch claimed the ID) or TIMEOUT. The block sits between the top-level CPU register decode and the first/last openflow switch register nodes.

---
 rtl/openflow_reg_ring_master.sv | 229 ++++++++++++++++++++++
 tb/tb_openflow_reg_ring_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openflow_reg_ring_master.sv
// Register-ring master: round-robin arbitration, one transaction in flight on the switch ring.
// Define REG_RING_STATS_EN to add saturating ok/miss/timeout/stray event counters.
`ifndef SWITCH_REG_CTRL_WIDTH
`define SWITCH_REG_CTRL_WIDTH 8
`endif
`ifndef SWITCH_REG_WRITE_BUS_WIDTH
`define SWITCH_REG_WRITE_BUS_WIDTH 32
`endif
`ifndef SWITCH_REG_READ_BUS_WIDTH
`define SWITCH_REG_READ_BUS_WIDTH 32
`endif

module openflow_reg_ring_master #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [`SWITCH_REG_READ_BUS_WIDTH-1:0] TIMEOUT_RESULT = 'hdead_0000,
    parameter logic [`SWITCH_REG_READ_BUS_WIDTH-1:0] MISS_RESULT = 'hdead_0001
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NUM_REQ-1:0]                             req_vld_i,
    input  logic [NUM_REQ*`SWITCH_REG_CTRL_WIDTH-1:0]      req_ctrl_i,
    input  logic [NUM_REQ*`SWITCH_REG_WRITE_BUS_WIDTH-1:0] req_wr_data_i,
    output logic [NUM_REQ-1:0]                             req_rdy_o,
    output logic [NUM_REQ-1:0]                             rsp_vld_o,
    output logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]          rsp_rd_data_o,
    output logic [1:0]                                     rsp_status_o,
    output logic [`SWITCH_REG_WRITE_BUS_WIDTH-1:0]         ring_out_wr_data_bus_o,
    output logic [`SWITCH_REG_CTRL_WIDTH-1:0]              ring_out_ctrl_o,
    output logic                                           ring_out_vld_o,
    output logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]          ring_out_rd_data_bus_o,
    output logic                                           ring_out_ack_o,
`ifdef REG_RING_STATS_EN
    output logic [31:0]                                    stat_ok_o,
    output logic [31:0]                                    stat_miss_o,
    output logic [31:0]                                    stat_timeout_o,
    output logic [31:0]                                    stat_stray_o,
`endif
    input  logic [`SWITCH_REG_WRITE_BUS_WIDTH-1:0]         ring_in_wr_data_bus_i,
    input  logic [`SWITCH_REG_CTRL_WIDTH-1:0]              ring_in_ctrl_i,
    input  logic                                           ring_in_vld_i,
    input  logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]          ring_in_rd_data_bus_i,
    input  logic                                           ring_in_ack_i
);
    localparam int unsigned CW = `SWITCH_REG_CTRL_WIDTH;
    localparam int unsigned WW = `SWITCH_REG_WRITE_BUS_WIDTH;
    localparam int unsigned RW = `SWITCH_REG_READ_BUS_WIDTH;
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d, grant_q, grant_d;
    logic [CW-1:0]       ctrl_q, ctrl_d, out_ctrl_q, out_ctrl_d;
    logic [WW-1:0]       wdata_q, wdata_d, out_wdata_q, out_wdata_d;
    logic [8:0]          count_q, count_d;
    logic                out_vld_q, out_vld_d;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d, req_rdy;
    logic [RW-1:0]       rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_status_q, rsp_status_d;
    logic                grant_any;
    logic [GW-1:0]       grant_idx;
    logic [CW-1:0]       sel_ctrl;
    logic [WW-1:0]       sel_wdata;
    logic                tail_busy, id_match;
    logic                ev_ok, ev_miss, ev_timeout, ev_stray;
    logic                unused_ring_in;

    // Ctrl layout: bit 0 is RD_WR_L, the remaining bits carry the switch ID.
    assign unused_ring_in = ^{ring_in_wr_data_bus_i, ring_in_ctrl_i[0]};
    assign tail_busy      = ring_in_vld_i | ring_in_ack_i;
    assign id_match       = (ring_in_ctrl_i[CW-1:1] == ctrl_q[CW-1:1]);

    always_comb begin
        logic [GW-1:0] cand;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((32'(last_grant_q) + i) % NUM_REQ);
            if (!grant_any && req_vld_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_ctrl  = req_ctrl_i[32'(grant_idx)*CW +: CW];
    assign sel_wdata = req_wr_data_i[32'(grant_idx)*WW +: WW];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ctrl_d       = ctrl_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        out_vld_d    = 1'b0;
        out_ctrl_d   = '0;
        out_wdata_d  = '0;
        rsp_vld_d    = '0;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        req_rdy      = '0;
        ev_ok        = 1'b0;
        ev_miss      = 1'b0;
        ev_timeout   = 1'b0;
        ev_stray     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ev_stray = tail_busy;
                if (grant_any) begin
                    req_rdy[grant_idx] = 1'b1;
                    grant_d      = grant_idx;
                    last_grant_d = grant_idx;
                    ctrl_d       = sel_ctrl;
                    wdata_d      = sel_wdata;
                    out_vld_d    = 1'b1;
                    out_ctrl_d   = sel_ctrl;
                    out_wdata_d  = sel_wdata;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                ev_stray = tail_busy;
                count_d  = 9'(TIMEOUT);
                state_d  = StWait;
            end
            StWait: begin
                count_d = count_q - 9'd1;
                if (ring_in_ack_i && id_match) begin
                    ev_ok        = 1'b1;
                    rsp_data_d   = ring_in_rd_data_bus_i;
                    rsp_status_d = 2'b00;
                end else if (ring_in_vld_i && id_match) begin
                    ev_miss      = 1'b1;
                    rsp_data_d   = MISS_RESULT;
                    rsp_status_d = 2'b01;
                end else begin
                    ev_stray = tail_busy;
                    // Writes are posted: silence until the window closes means a node claimed it.
                    if (count_q == '0) begin
                        ev_timeout   = ctrl_q[0];
                        ev_ok        = ~ctrl_q[0];
                        rsp_data_d   = ctrl_q[0] ? TIMEOUT_RESULT : '0;
                        rsp_status_d = ctrl_q[0] ? 2'b10 : 2'b00;
                    end
                end
                if (ev_ok || ev_miss || ev_timeout) begin
                    rsp_vld_d[grant_q] = 1'b1;
                    state_d            = StResp;
                end
            end
            StResp: begin
                ev_stray = tail_busy;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            ctrl_q       <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
            out_vld_q    <= 1'b0;
            out_ctrl_q   <= '0;
            out_wdata_q  <= '0;
            rsp_vld_q    <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ctrl_q       <= ctrl_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            out_vld_q    <= out_vld_d;
            out_ctrl_q   <= out_ctrl_d;
            out_wdata_q  <= out_wdata_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Accept is combinational, so it is gated by reset to keep it low while reset is held.
    assign req_rdy_o              = req_rdy & {NUM_REQ{rst_ni}};
    assign rsp_vld_o              = rsp_vld_q;
    assign rsp_rd_data_o          = rsp_data_q;
    assign rsp_status_o           = rsp_status_q;
    assign ring_out_vld_o         = out_vld_q;
    assign ring_out_ctrl_o        = out_ctrl_q;
    assign ring_out_wr_data_bus_o = out_wdata_q;
    assign ring_out_rd_data_bus_o = '0;
    assign ring_out_ack_o         = 1'b0;

`ifdef REG_RING_STATS_EN
    logic [31:0] stat_ok_q, stat_miss_q, stat_timeout_q, stat_stray_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_ok_q      <= '0;
            stat_miss_q    <= '0;
            stat_timeout_q <= '0;
            stat_stray_q   <= '0;
        end else begin
            if (ev_ok && stat_ok_q != '1) stat_ok_q <= stat_ok_q + 32'd1;
            if (ev_miss && stat_miss_q != '1) stat_miss_q <= stat_miss_q + 32'd1;
            if (ev_timeout && stat_timeout_q != '1) stat_timeout_q <= stat_timeout_q + 32'd1;
            if (ev_stray && stat_stray_q != '1) stat_stray_q <= stat_stray_q + 32'd1;
        end
    end

    assign stat_ok_o      = stat_ok_q;
    assign stat_miss_o    = stat_miss_q;
    assign stat_timeout_o = stat_timeout_q;
    assign stat_stray_o   = stat_stray_q;
`else
    logic unused_events;
    assign unused_events = ^{ev_ok, ev_miss, ev_timeout, ev_stray};
`endif

endmodule

// File: tb/tb_openflow_reg_ring_master.sv
// Randomized scoreboard bench for openflow_reg_ring_master with a behavioural ring-tail model.
`ifndef SWITCH_REG_CTRL_WIDTH
`define SWITCH_REG_CTRL_WIDTH 8
`endif
`ifndef SWITCH_REG_WRITE_BUS_WIDTH
`define SWITCH_REG_WRITE_BUS_WIDTH 32
`endif
`ifndef SWITCH_REG_READ_BUS_WIDTH
`define SWITCH_REG_READ_BUS_WIDTH 32
`endif

module tb_openflow_reg_ring_master;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned CW = `SWITCH_REG_CTRL_WIDTH;
    localparam int unsigned WW = `SWITCH_REG_WRITE_BUS_WIDTH;
    localparam int unsigned RW = `SWITCH_REG_READ_BUS_WIDTH;
    localparam logic [RW-1:0] TO_RES = 'hdead_0000;
    localparam logic [RW-1:0] MISS_RES = 'hdead_0001;
    localparam int KAck = 0, KMiss = 1, KNone = 2, KBoth = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_vld = '0;
    logic [NUM_REQ*CW-1:0] req_ctrl = '0;
    logic [NUM_REQ*WW-1:0] req_wr_data = '0;
    logic [NUM_REQ-1:0]    req_rdy, rsp_vld;
    logic [RW-1:0]         rsp_rd_data;
    logic [1:0]            rsp_status;
    logic [WW-1:0]         ring_out_wr_data_bus;
    logic [CW-1:0]         ring_out_ctrl;
    logic                  ring_out_vld;
    logic [RW-1:0]         ring_out_rd_data_bus;
    logic                  ring_out_ack;
    logic [WW-1:0]         ring_in_wr_data_bus = '0;
    logic [CW-1:0]         ring_in_ctrl = '0;
    logic                  ring_in_vld = 1'b0;
    logic [RW-1:0]         ring_in_rd_data_bus = '0;
    logic                  ring_in_ack = 1'b0;
`ifdef REG_RING_STATS_EN
    logic [31:0] stat_ok, stat_miss, stat_timeout, stat_stray;
`endif

    openflow_reg_ring_master #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_vld_i(req_vld), .req_ctrl_i(req_ctrl), .req_wr_data_i(req_wr_data),
        .req_rdy_o(req_rdy), .rsp_vld_o(rsp_vld), .rsp_rd_data_o(rsp_rd_data),
        .rsp_status_o(rsp_status),
        .ring_out_wr_data_bus_o(ring_out_wr_data_bus), .ring_out_ctrl_o(ring_out_ctrl),
        .ring_out_vld_o(ring_out_vld), .ring_out_rd_data_bus_o(ring_out_rd_data_bus),
        .ring_out_ack_o(ring_out_ack),
`ifdef REG_RING_STATS_EN
        .stat_ok_o(stat_ok), .stat_miss_o(stat_miss), .stat_timeout_o(stat_timeout),
        .stat_stray_o(stat_stray),
`endif
        .ring_in_wr_data_bus_i(ring_in_wr_data_bus), .ring_in_ctrl_i(ring_in_ctrl),
        .ring_in_vld_i(ring_in_vld), .ring_in_rd_data_bus_i(ring_in_rd_data_bus),
        .ring_in_ack_i(ring_in_ack)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int unsigned g;
        logic [1:0]  status;
        logic [RW-1:0] data;
        longint      at;
    } exp_t;

    typedef struct {
        longint        t;
        logic [CW-1:0] ctrl;
        logic [WW-1:0] wdata;
        int            kind;
        int            k;
        int            s;
        logic [RW-1:0] rdata;
    } plan_t;

    exp_t  sb_q[$];
    plan_t plan_q[$];
    logic [NUM_REQ-1:0] grant_log[$];

    int unsigned last_grant = NUM_REQ - 1;
    bit            pending[NUM_REQ];
    logic [CW-1:0] p_ctrl[NUM_REQ];
    logic [WW-1:0] p_data[NUM_REQ];
    int exp_ok = 0, exp_miss = 0, exp_to = 0, exp_stray = 0;
    bit stray_req = 1'b0;
    logic [CW-1:0] stray_ctrl = '0;

    task automatic new_req(input int unsigned r);
        logic [6:0] id;
        id = 7'($urandom_range(0, 126));
        pending[r] = 1'b1;
        p_ctrl[r] = CW'({id, 1'($urandom_range(0, 1))});
        p_data[r] = WW'($urandom);
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_vld[r] = pending[r];
            req_ctrl[r*CW +: CW] = p_ctrl[r];
            req_wr_data[r*WW +: WW] = p_data[r];
        end
    endtask

    function automatic bit any_pending();
        bit a;
        a = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) a |= pending[r];
        return a;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txns(input int n, input bit force_both);
        int i;
        i = 0;
        while (i < n || any_pending()) begin
            int unsigned g, c;
            int sel, w;
            bit found;
            plan_t p;
            exp_t e;
            if (i < n) begin
                for (int r = 0; r < NUM_REQ; r++)
                    if (!pending[r] && (force_both || $urandom_range(0, 1) == 1)) new_req(r);
                if (!any_pending()) new_req($urandom_range(0, NUM_REQ - 1));
            end
            drive_reqs();
            found = 1'b0;
            g = 0;
            for (int j = 1; j <= NUM_REQ; j++) begin
                c = (last_grant + j) % NUM_REQ;
                if (!found && pending[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
            w = 0;
            @(negedge clk);
            while (req_rdy == '0 && w < int'(TIMEOUT) + 20) begin
                @(negedge clk);
                w++;
            end
            check("grant", 64'(req_rdy), 64'(1) << g);
            grant_log.push_back(req_rdy);
            last_grant = g;
            p.t = cyc;
            p.ctrl = p_ctrl[g];
            p.wdata = p_data[g];
            sel = $urandom_range(0, 9);
            p.kind = (sel < 4) ? KAck : (sel < 6) ? KMiss : (sel < 7) ? KNone : KBoth;
            p.k = $urandom_range(2, 20);
            p.s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, p.k - 1)) : -1;
            p.rdata = RW'($urandom);
            e.g = g;
            if (p.kind == KAck || p.kind == KBoth) begin
                e.status = 2'b00; e.data = p.rdata; e.at = p.t + 3 + p.k; exp_ok++;
            end else if (p.kind == KMiss) begin
                e.status = 2'b01; e.data = MISS_RES; e.at = p.t + 3 + p.k; exp_miss++;
            end else begin
                e.at = p.t + TIMEOUT + 3;
                if (p.ctrl[0]) begin
                    e.status = 2'b10; e.data = TO_RES; exp_to++;
                end else begin
                    e.status = 2'b00; e.data = '0; exp_ok++;
                end
            end
            if (p.s >= 0) exp_stray++;
            sb_q.push_back(e);
            plan_q.push_back(p);
            pending[g] = 1'b0;
            @(posedge clk);
            #1;
            drive_reqs();
            i++;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() > 0 && w < int'(TIMEOUT) + 50) begin
            @(posedge clk);
            w++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef REG_RING_STATS_EN
        check("stat_ok", 64'(stat_ok), 64'(exp_ok));
        check("stat_miss", 64'(stat_miss), 64'(exp_miss));
        check("stat_timeout", 64'(stat_timeout), 64'(exp_to));
        check("stat_stray", 64'(stat_stray), 64'(exp_stray));
`endif
    endtask

    // Ring-tail model: sole driver of ring_in_*.
    initial begin
        plan_t p;
        longint endc;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                @(posedge clk); #1;
                ring_in_ack = 1'b1;
                ring_in_ctrl = stray_ctrl;
                ring_in_rd_data_bus = RW'($urandom);
                @(posedge clk); #1;
                ring_in_ack = 1'b0;
                ring_in_ctrl = '0;
                stray_req = 1'b0;
            end else if (plan_q.size() > 0) begin
                p = plan_q.pop_front();
                while (cyc < p.t + 1) @(negedge clk);
                check("ring_out_vld", 64'(ring_out_vld), 64'd1);
                check("ring_out_ctrl", 64'(ring_out_ctrl), 64'(p.ctrl));
                check("ring_out_wdata", 64'(ring_out_wr_data_bus), 64'(p.wdata));
                check("ring_out_ack_rd", 64'({ring_out_ack, ring_out_rd_data_bus}), 64'd0);
                endc = p.t + 2 + ((p.kind == KNone) ? 0 : p.k);
                if (p.s >= 0 && p.t + 2 + p.s > endc) endc = p.t + 2 + p.s;
                for (longint c = p.t + 2; c <= endc; c++) begin
                    @(posedge clk); #1;
                    if (c == p.t + 2) check("ring_out_vld_pulse", 64'(ring_out_vld), 64'd0);
                    ring_in_ack = 1'b0;
                    ring_in_vld = 1'b0;
                    ring_in_ctrl = '0;
                    ring_in_wr_data_bus = WW'($urandom);
                    if (p.s >= 0 && c == p.t + 2 + p.s) begin
                        ring_in_ack = 1'b1;
                        ring_in_ctrl = p.ctrl ^ CW'(2);
                        ring_in_rd_data_bus = RW'($urandom);
                    end
                    if (p.kind != KNone && c == p.t + 2 + p.k) begin
                        ring_in_ctrl = p.ctrl;
                        ring_in_rd_data_bus = p.rdata;
                        ring_in_ack = (p.kind == KAck || p.kind == KBoth);
                        ring_in_vld = (p.kind == KMiss || p.kind == KBoth);
                    end
                end
                @(posedge clk); #1;
                ring_in_ack = 1'b0;
                ring_in_vld = 1'b0;
                ring_in_ctrl = '0;
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_vld !== '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_vld), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_vld", 64'(rsp_vld), 64'(1) << e.g);
                    check("rsp_status", 64'(rsp_status), 64'(e.status));
                    check("rsp_rd_data", 64'(rsp_rd_data), 64'(e.data));
                    check("rsp_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        int w;
        plan_t p;
        for (int r = 0; r < NUM_REQ; r++) begin
            pending[r] = 1'b0; p_ctrl[r] = '0; p_data[r] = '0;
        end
        req_vld = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_ring_out", 64'({ring_out_vld, ring_out_ctrl, ring_out_ack}), 64'd0);
        check("rst_ring_out_wdata", 64'(ring_out_wr_data_bus), 64'd0);
        check("rst_rsp", 64'({rsp_vld, rsp_status}), 64'd0);
        check("rst_rsp_data", 64'(rsp_rd_data), 64'd0);
        req_vld = '0;
        rst_n = 1'b1;
        run_txns(24, 1'b0);
        drain();
        check_stats();

        // Stray ack while idle must be ignored.
        stray_ctrl = CW'($urandom);
        stray_req = 1'b1;
        exp_stray++;
        w = 0;
        while (stray_req && w < 10) begin @(posedge clk); w++; end
        repeat (2) @(posedge clk);
        #1;
        check("idle_stray_no_rsp", 64'(sb_q.size()), 64'd0);
        check_stats();

        // Abort a requester-0 transaction mid-WAIT with asynchronous reset.
        new_req(0);
        drive_reqs();
        w = 0;
        @(negedge clk);
        while (req_rdy == '0 && w < 20) begin @(negedge clk); w++; end
        check("abort_grant", 64'(req_rdy), 64'd1);
        p.t = cyc; p.ctrl = p_ctrl[0]; p.wdata = p_data[0];
        p.kind = KNone; p.k = 0; p.s = -1; p.rdata = '0;
        plan_q.push_back(p);
        pending[0] = 1'b0;
        @(posedge clk); #1;
        drive_reqs();
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rsp", 64'({rsp_vld, rsp_status}), 64'd0);
        check("async_rst_rsp_data", 64'(rsp_rd_data), 64'd0);
        check("async_rst_ring_out", 64'({ring_out_vld, ring_out_ctrl}), 64'd0);
        last_grant = NUM_REQ - 1;
        exp_ok = 0; exp_miss = 0; exp_to = 0; exp_stray = 0;
        new_req(0);
        new_req(1);
        drive_reqs();
        #1;
        check("rst_held_req_rdy", 64'(req_rdy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_stats();
        rst_n = 1'b1;
        grant_log.delete();
        run_txns(4, 1'b1);
        drain();
        for (int i = 0; i < 4; i++)
            check("fair_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
